// File: rtl/mips789_cop_pkg.sv
// Shared mips789 coprocessor-bus command codes and key peripheral register map.
// Pure definitions, no timing and no flow control.
package mips789_cop_pkg;

    localparam logic [3:0] COP_NOP = 4'd0;
    localparam logic [3:0] COP_LW  = 4'd1;
    localparam logic [3:0] COP_SW  = 4'd2;

    // Register index taken from addr[3:2]
    localparam logic [1:0] KEY_STATUS = 2'd0;
    localparam logic [1:0] KEY_COUNT  = 2'd1;
    localparam logic [1:0] KEY_CTRL   = 2'd2;
    localparam logic [1:0] KEY_VECTOR = 2'd3;

    typedef struct packed {
        logic irq_en;
        logic level;
        logic pending;
    } key_status_t;

    function automatic logic [31:0] key_status_word(input key_status_t s);
        return {29'b0, s};
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Key synchroniser and debouncer: level follows key after 2 + DEB_CYCLES cycles,
// press is a one-cycle registered pulse on the 0->1 accepted edge; no backpressure.
module key_debounce #(
    parameter int DEB_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          sample;

    // Raw key is active-low; the synchroniser holds the raw level
    assign sample = ~sync_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
            level  <= 1'b0;
            press  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], key};
            press  <= 1'b0;
            if (sample == level) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level <= sample;
                cnt_q <= '0;
                press <= sample;
            end else if (cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mips_key_irq.sv
// Push-button peripheral on the cop bus: press counter, pending flag, irq and vector.
// Reads return on the next cycle, writes land at the command-cycle edge; no backpressure.
module mips_key_irq
    import mips789_cop_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_8010,
    parameter int          DEB_CYCLES = 250000,
    parameter logic [31:0] VEC_RESET  = 32'h0000_0050
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key,
    input  logic [31:0] addr_i,
    input  logic [31:0] din,
    input  logic [3:0]  dmem_ctl_i,
    output logic [31:0] dout,
    output logic        irq_o,
    output logic [31:0] irq_addr_o
);

    logic        level;
    logic        press;
    logic        sel;
    logic        rd;
    logic        wr;
    logic [1:0]  off;
    logic        wr_count;
    logic        wr_ctrl;
    logic        wr_vec;
    logic [15:0] count_q;
    logic        pending_q;
    logic        irq_en_q;
    logic [31:0] vec_q;
    logic [31:0] rd_data;
    logic        unused_addr_lsb;

    key_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
        .clk   (clk),
        .rst   (rst),
        .key   (key),
        .level (level),
        .press (press)
    );

    assign sel             = (addr_i[31:4] == BASE_ADDR[31:4]);
    assign off             = addr_i[3:2];
    assign rd              = sel && (dmem_ctl_i == COP_LW);
    assign wr              = sel && (dmem_ctl_i == COP_SW);
    assign wr_count        = wr && (off == KEY_COUNT);
    assign wr_ctrl         = wr && (off == KEY_CTRL);
    assign wr_vec          = wr && (off == KEY_VECTOR);
    assign unused_addr_lsb = ^addr_i[1:0];
    assign irq_addr_o      = vec_q;

    always_comb begin
        rd_data = '0;
        case (off)
            KEY_STATUS: rd_data = key_status_word('{irq_en: irq_en_q, level: level, pending: pending_q});
            KEY_COUNT:  rd_data = {16'b0, count_q};
            KEY_CTRL:   rd_data = {31'b0, irq_en_q};
            KEY_VECTOR: rd_data = vec_q;
            default:    rd_data = '0;
        endcase
    end

    // A press landing with a COUNT write counts as the first press after the clear
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (wr_count) begin
            count_q <= press ? 16'd1 : 16'd0;
        end else if (press) begin
            count_q <= count_q + 16'd1;
        end
    end

    // Set beats write-1-to-clear so a press is never lost
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= 1'b0;
        end else if (press) begin
            pending_q <= 1'b1;
        end else if (wr_ctrl && din[1]) begin
            pending_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en_q <= 1'b0;
            vec_q    <= VEC_RESET;
            irq_o    <= 1'b0;
            dout     <= '0;
        end else begin
            if (wr_ctrl) begin
                irq_en_q <= din[0];
            end
            if (wr_vec) begin
                vec_q <= din;
            end
            irq_o <= pending_q & irq_en_q;
            dout  <= rd ? rd_data : 32'd0;
        end
    end

endmodule

// File: tb/tb_mips_key_irq.sv
// Scoreboarded bench for mips_key_irq with DEB_CYCLES=4 and BASE_ADDR=32'h8010.
module tb_mips_key_irq;
    import mips789_cop_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        key;
    logic [31:0] addr_i;
    logic [31:0] din;
    logic [3:0]  dmem_ctl_i;
    logic [31:0] dout;
    logic        irq_o;
    logic [31:0] irq_addr_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic rd_prev = 1'b0;

    mips_key_irq #(
        .BASE_ADDR (32'h0000_8010),
        .DEB_CYCLES(4),
        .VEC_RESET (32'h0000_0050)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key        (key),
        .addr_i     (addr_i),
        .din        (din),
        .dmem_ctl_i (dmem_ctl_i),
        .dout       (dout),
        .irq_o      (irq_o),
        .irq_addr_o (irq_addr_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a read issued in the previous cycle must present the queued value, else dout is 0
    always @(posedge clk) rd_prev <= (dmem_ctl_i == COP_LW);

    always @(negedge clk) begin
        logic [31:0] e;
        if (rd_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dout_unexpected: got %h expected no read at %0t", dout, $time);
            end else begin
                e = exp_q.pop_front();
                chk("dout_read", dout, e);
            end
        end else begin
            chk("dout_idle", dout, 32'd0);
        end
    end

    task automatic bus(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] e);
        dmem_ctl_i = cmd;
        addr_i     = a;
        din        = d;
        if (cmd == COP_LW) exp_q.push_back(e);
        @(posedge clk);
        #1;
        dmem_ctl_i = COP_NOP;
        addr_i     = '0;
        din        = '0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e);
        bus(COP_LW, a, 32'd0, e);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus(COP_SW, a, d, 32'd0);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        key        = 1'b1;
        addr_i     = '0;
        din        = '0;
        dmem_ctl_i = COP_NOP;
        wait_cyc(3);
        chk("rst_dout", dout, 32'd0);
        chk("rst_irq", {31'b0, irq_o}, 32'd0);
        chk("rst_vec", irq_addr_o, 32'h50);
        rst = 1'b0;

        rd(32'h8010, 32'h0);
        rd(32'h801C, 32'h50);
        chk("idle_irq", {31'b0, irq_o}, 32'd0);

        // Long press with irq disabled, then enable
        key = 1'b0;
        wait_cyc(20);
        rd(32'h8010, 32'h3);
        rd(32'h8014, 32'h1);
        chk("held_irq_off", {31'b0, irq_o}, 32'd0);
        wr(32'h8018, 32'h1);
        chk("en_irq_pre", {31'b0, irq_o}, 32'd0);
        wait_cyc(1);
        chk("en_irq_post", {31'b0, irq_o}, 32'd1);
        rd(32'h8010, 32'h7);
        key = 1'b1;
        wait_cyc(20);
        rd(32'h8010, 32'h5);
        rd(32'h8014, 32'h1);
        wr(32'h8018, 32'h2);
        wr(32'h8014, 32'h0);
        rd(32'h8010, 32'h0);
        rd(32'h8014, 32'h0);

        // Glitch shorter than the debounce window
        key = 1'b0;
        wait_cyc(3);
        key = 1'b1;
        wait_cyc(15);
        rd(32'h8014, 32'h0);
        rd(32'h8010, 32'h0);

        // Key-to-irq latency DEB_CYCLES+4
        wr(32'h8018, 32'h1);
        key = 1'b0;
        wait_cyc(7);
        chk("lat_irq_7", {31'b0, irq_o}, 32'd0);
        wait_cyc(1);
        chk("lat_irq_8", {31'b0, irq_o}, 32'd1);
        rd(32'h8010, 32'h7);
        wr(32'h8018, 32'h3);
        chk("clr_irq_pre", {31'b0, irq_o}, 32'd1);
        wait_cyc(1);
        chk("clr_irq_post", {31'b0, irq_o}, 32'd0);
        rd(32'h8010, 32'h6);
        rd(32'h8014, 32'h1);
        key = 1'b1;
        wait_cyc(15);

        // Press event coinciding with a pending clear: set wins
        key = 1'b0;
        wait_cyc(6);
        wr(32'h8018, 32'h2);
        rd(32'h8010, 32'h3);
        rd(32'h8014, 32'h2);
        key = 1'b1;
        wait_cyc(15);

        // Press event coinciding with a COUNT write: ends at 1
        wr(32'h8018, 32'h2);
        key = 1'b0;
        wait_cyc(6);
        wr(32'h8014, 32'h0);
        rd(32'h8014, 32'h1);
        key = 1'b1;
        wait_cyc(15);

        // Count wrap from 16'hFFFF
        force dut.count_q = 16'hFFFF;
        wait_cyc(1);
        release dut.count_q;
        rd(32'h8014, 32'hFFFF);
        wr(32'h8018, 32'h2);
        key = 1'b0;
        wait_cyc(12);
        rd(32'h8014, 32'h0);
        rd(32'h8010, 32'h3);
        key = 1'b1;
        wait_cyc(15);

        // Vector register, decode and read-only paths
        wr(32'h801C, 32'hDEAD_BEEF);
        chk("vec_write", irq_addr_o, 32'hDEAD_BEEF);
        rd(32'h8020, 32'h0);
        rd(32'h801C, 32'hDEAD_BEEF);
        rd(32'h801F, 32'hDEAD_BEEF);
        rd(32'h8018, 32'h0);
        wr(32'h8018, 32'h1);
        rd(32'h8018, 32'h1);
        wr(32'h803C, 32'h1234_5678);
        chk("vec_unsel", irq_addr_o, 32'hDEAD_BEEF);
        bus(4'd3, 32'h8010, 32'h0, 32'h0);
        wr(32'h8010, 32'hFFFF_FFFF);
        rd(32'h8010, 32'h5);
        wait_cyc(1);
        chk("final_irq", {31'b0, irq_o}, 32'd1);

        wait_cyc(3);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending reads expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
